// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: per-stage write-enable/flush control with load-use, memory-wait and halt-drain FSM
module pipeline_stall_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       no_op_req,
    input  logic [3:0]       hold_req,
    input  logic             branch_taken,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic             halt_id,
    output logic             pc_we,
    output logic [3:0]       stage_we,
    output logic [3:0]       stage_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
    typedef enum logic [2:0] {RUN, LU_BUBBLE, MEM_WAIT, DRAIN, HALTED} state_t;
    state_t state, state_n;
    logic [DW-1:0] drain_cnt, drain_n;
    logic [3:0] hold_m, nop_m;
    logic load_use, flush_inc;
    // the bubble cycle masks the load-use pair so one load never gets two bubbles
    assign hold_m = state == LU_BUBBLE ? hold_req & 4'b1110 : hold_req;
    assign nop_m = state == LU_BUBBLE ? no_op_req & 4'b1101 : no_op_req;
    assign load_use = hold_m[0] & nop_m[1];
    assign halted = (state == HALTED) & ~rst;
    // control outputs and next state, highest-priority event first
    always_comb begin
        pc_we = 1'b1;
        stage_we = 4'hf;
        stage_flush = 4'h0;
        state_n = state;
        drain_n = drain_cnt;
        flush_inc = 1'b0;
        if (rst) begin
            pc_we = 1'b0;
            stage_we = 4'h0;
            stage_flush = 4'hf;
        end else if (state == HALTED) begin
            pc_we = 1'b0;
            stage_we = 4'h0;
        end else if (dmem_busy) begin
            pc_we = 1'b0;
            stage_we = 4'b1000;
            stage_flush = 4'b1000;
            state_n = state == DRAIN ? DRAIN : MEM_WAIT;
        end else if (state == DRAIN) begin
            pc_we = 1'b0;
            stage_flush = 4'b0001;
            state_n = drain_cnt == '0 ? HALTED : DRAIN;
            drain_n = drain_cnt == '0 ? drain_cnt : drain_cnt - 1'b1;
        end else begin
            state_n = RUN;
            if (load_use) begin
                pc_we = 1'b0;
                stage_we = 4'b1110;
                stage_flush = 4'b0010;
                state_n = LU_BUBBLE;
            end else if (halt_id) begin
                pc_we = 1'b0;
                stage_flush = 4'b0001;
                drain_n = DW'(DRAIN_CYCLES - 1);
                state_n = DRAIN;
            end else if (branch_taken) begin
                stage_flush = 4'b0001;
                flush_inc = ~imem_busy;
            end else begin
                stage_flush = nop_m;
                stage_we = ~hold_m | nop_m;
                pc_we = ~hold_m[0];
            end
            if (imem_busy) begin
                pc_we = 1'b0;
                stage_flush[0] = 1'b1;
            end
        end
    end
    // state, drain counter and saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_n;
            drain_cnt <= drain_n;
            if (~pc_we && state != HALTED && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && ~&flush_cnt) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed scenario bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] no_op_req, hold_req;
    logic branch_taken, imem_busy, dmem_busy, halt_id;
    logic pc_we, halted, pc_we4, halted4;
    logic [3:0] stage_we, stage_flush, stage_we4, stage_flush4, stall_cnt4, flush_cnt4;
    logic [15:0] stall_cnt, flush_cnt;
    logic [8:0] ctl;
    int n_cmp = 0;
    int n_bad = 0;
    assign ctl = {pc_we, stage_we, stage_flush};
    pipeline_stall_ctrl dut (
        .clk(clk), .rst(rst), .no_op_req(no_op_req), .hold_req(hold_req),
        .branch_taken(branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy), .halt_id(halt_id),
        .pc_we(pc_we), .stage_we(stage_we), .stage_flush(stage_flush), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
    pipeline_stall_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .no_op_req(no_op_req), .hold_req(hold_req),
        .branch_taken(branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy), .halt_id(halt_id),
        .pc_we(pc_we4), .stage_we(stage_we4), .stage_flush(stage_flush4), .halted(halted4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );
    always #5 clk = ~clk;
    task automatic idle();
        no_op_req = 4'h0;
        hold_req = 4'h0;
        branch_taken = 1'b0;
        imem_busy = 1'b0;
        dmem_busy = 1'b0;
        halt_id = 1'b0;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        #1;
        n_cmp++; if (ctl !== 9'h00f) begin n_bad++; $display("FAIL reset_ctl: got %h want %h", ctl, 9'h00f); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        rst = 1'b0;
        #1;
        n_cmp++; if (ctl !== 9'h1f0) begin n_bad++; $display("FAIL reset_idle_ctl: got %h want %h", ctl, 9'h1f0); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        n_cmp++; if (flush_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_flush: got %0d want 0", flush_cnt); end
        tick();
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_idle_stall: got %0d want 0", stall_cnt); end
    endtask
    task automatic test_load_use();
        do_reset();
        hold_req = 4'b0001;
        no_op_req = 4'b0010;
        #1;
        n_cmp++; if (ctl !== 9'h0e2) begin n_bad++; $display("FAIL lu_ctl: got %h want %h", ctl, 9'h0e2); end
        tick();
        #1;
        n_cmp++; if (ctl !== 9'h1f0) begin n_bad++; $display("FAIL lu_bubble_ctl: got %h want %h", ctl, 9'h1f0); end
        n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_stall: got %0d want 1", stall_cnt); end
        idle();
        tick();
        n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_stall_after: got %0d want 1", stall_cnt); end
    endtask
    task automatic test_branch_lu();
        do_reset();
        hold_req = 4'b0001;
        no_op_req = 4'b0010;
        branch_taken = 1'b1;
        #1;
        n_cmp++; if (ctl !== 9'h0e2) begin n_bad++; $display("FAIL br_lu_ctl: got %h want %h", ctl, 9'h0e2); end
        tick();
        n_cmp++; if (flush_cnt !== 16'd0) begin n_bad++; $display("FAIL br_lu_flush: got %0d want 0", flush_cnt); end
        hold_req = 4'h0;
        no_op_req = 4'h0;
        #1;
        n_cmp++; if (ctl !== 9'h1f1) begin n_bad++; $display("FAIL br_ctl: got %h want %h", ctl, 9'h1f1); end
        tick();
        n_cmp++; if (flush_cnt !== 16'd1) begin n_bad++; $display("FAIL br_flush: got %0d want 1", flush_cnt); end
        idle();
    endtask
    task automatic test_dmem();
        do_reset();
        dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (ctl !== 9'h088) begin n_bad++; $display("FAIL dmem_ctl[%0d]: got %h want %h", i, ctl, 9'h088); end
            tick();
        end
        dmem_busy = 1'b0;
        #1;
        n_cmp++; if (ctl !== 9'h1f0) begin n_bad++; $display("FAIL dmem_release_ctl: got %h want %h", ctl, 9'h1f0); end
        tick();
        n_cmp++; if (stall_cnt !== 16'd3) begin n_bad++; $display("FAIL dmem_stall: got %0d want 3", stall_cnt); end
    endtask
    task automatic test_halt();
        do_reset();
        halt_id = 1'b1;
        #1;
        n_cmp++; if (ctl !== 9'h0f1) begin n_bad++; $display("FAIL halt_ctl: got %h want %h", ctl, 9'h0f1); end
        tick();
        halt_id = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i >= 4) begin branch_taken = 1'b1; hold_req = 4'hf; end
            #1;
            n_cmp++; if (halted !== (i >= 4)) begin n_bad++; $display("FAIL halt_halted[%0d]: got %b want %b", i, halted, i >= 4); end
            n_cmp++; if (ctl !== (i >= 4 ? 9'h000 : 9'h0f1)) begin n_bad++; $display("FAIL halt_drain_ctl[%0d]: got %h", i, ctl); end
            tick();
        end
        n_cmp++; if (stall_cnt !== 16'd4) begin n_bad++; $display("FAIL halt_stall: got %0d want 4", stall_cnt); end
        n_cmp++; if (flush_cnt !== 16'd0) begin n_bad++; $display("FAIL halt_flush: got %0d want 0", flush_cnt); end
        rst = 1'b1;
        idle();
        #1;
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_rst_halted: got %b want 0", halted); end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (ctl !== 9'h1f0) begin n_bad++; $display("FAIL halt_after_rst_ctl: got %h want %h", ctl, 9'h1f0); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL halt_after_rst_stall: got %0d want 0", stall_cnt); end
    endtask
    task automatic test_halt_busy();
        do_reset();
        halt_id = 1'b1;
        tick();
        halt_id = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            dmem_busy = (i == 1 || i == 2);
            #1;
            n_cmp++; if (halted !== (i >= 6)) begin n_bad++; $display("FAIL hb_halted[%0d]: got %b want %b", i, halted, i >= 6); end
            if (i <= 2) begin
                n_cmp++; if (ctl !== 9'h088) begin n_bad++; $display("FAIL hb_busy_ctl[%0d]: got %h want %h", i, ctl, 9'h088); end
            end
            tick();
        end
        idle();
    endtask
    task automatic test_reset_mid_drain();
        do_reset();
        halt_id = 1'b1;
        tick();
        halt_id = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (ctl !== 9'h1f0) begin n_bad++; $display("FAIL mid_rst_ctl: got %h want %h", ctl, 9'h1f0); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_rst_stall: got %0d want 0", stall_cnt); end
        halt_id = 1'b1;
        tick();
        halt_id = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_cmp++; if (halted !== (i == 4)) begin n_bad++; $display("FAIL mid_rst_halted[%0d]: got %b want %b", i, halted, i == 4); end
            if (i < 4) tick();
        end
    endtask
    task automatic test_passthrough();
        logic [3:0] h [7] = '{4'b0100, 4'b0001, 4'b1000, 4'b0000, 4'b0110, 4'b0000, 4'b0000};
        logic [3:0] n [7] = '{4'b0000, 4'b0000, 4'b1000, 4'b0101, 4'b0010, 4'b0000, 4'b0000};
        logic ib [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic bt [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [8:0] e [7] = '{9'h1b0, 9'h0e0, 9'h1f8, 9'h1f5, 9'h1b2, 9'h0f1, 9'h0f1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            hold_req = h[i];
            no_op_req = n[i];
            imem_busy = ib[i];
            branch_taken = bt[i];
            #1;
            n_cmp++; if (ctl !== e[i]) begin n_bad++; $display("FAIL pass_ctl[%0d]: got %h want %h", i, ctl, e[i]); end
            tick();
        end
        idle();
        n_cmp++; if (stall_cnt !== 16'd3) begin n_bad++; $display("FAIL pass_stall: got %0d want 3", stall_cnt); end
    endtask
    task automatic test_saturation();
        do_reset();
        imem_busy = 1'b1;
        repeat (14) tick();
        n_cmp++; if (stall_cnt4 !== 4'he) begin n_bad++; $display("FAIL sat_stall_pre: got %h want e", stall_cnt4); end
        repeat (6) tick();
        n_cmp++; if (stall_cnt4 !== 4'hf) begin n_bad++; $display("FAIL sat_stall: got %h want f", stall_cnt4); end
        n_cmp++; if (stall_cnt !== 16'd20) begin n_bad++; $display("FAIL sat_stall_wide: got %0d want 20", stall_cnt); end
        imem_busy = 1'b0;
        branch_taken = 1'b1;
        repeat (20) tick();
        n_cmp++; if (flush_cnt4 !== 4'hf) begin n_bad++; $display("FAIL sat_flush: got %h want f", flush_cnt4); end
        n_cmp++; if (flush_cnt !== 16'd20) begin n_bad++; $display("FAIL sat_flush_wide: got %0d want 20", flush_cnt); end
        idle();
    endtask
    initial begin
        test_reset();
        test_load_use();
        test_branch_lu();
        test_dmem();
        test_halt();
        test_halt_busy();
        test_reset_mid_drain();
        test_passthrough();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
